multi_up_counter: RTL and testbench
===================================

Name: multi_up_counter

Overview:
- Parametrised successor to the single up-counter/compare peripheral: NCH independent up-counter channels, each with its own compare register, control register and status register.
- Channels share one register write/read port.
- Each channel counts rising edges of its own tick input and supports three modes: stop-on-match, auto-reload and free-run.
- Sits on the Synapse peripheral bus; per-channel level outputs feed the interrupt/event logic.

Parameters:
- WIDTH, 16, counter/compare/data width; must be >= 5.
- NCH, 4, number of channels, 1..16.
- CHW, max(1,$clog2(NCH)), derived channel-select width; not for override.

Ports:
- sysclk  in  1  system clock.
- sysreset  in  1  reset, asynchronous, active-high.
- data_in  in  WIDTH  write data.
- addr  in  CHW+2  {channel, sel}; sel 0=count, 1=compare, 2=control, 3=status.
- wr  in  1  write strobe for the register at addr, one cycle.
- data_out  out  WIDTH  combinational read of the register at addr; unused bits read 0.
- prescale_load  in  1  loads data_in into the shared prescaler divisor.
- tick_in  in  NCH  per-channel external tick; rising edges are counted.
- expired  out  NCH  level; cnt==compare per channel.
- irq  out  NCH  sticky match flag AND ctrl irq-enable bit, per channel.

Behaviour:
Reset (asynchronous, immediate):
- All cnt=0, compare=0, ctrl=0, status=0, prescaler divisor=0, tick history=0.
- expired=all-ones (because cnt==compare), irq=0, data_out reflects reset values.

Control register bits:
- [0] enable.
- [2:1] mode: 00 stop-on-match, 01 auto-reload, 10 free-run, 11 treated as 00.
- [3] tick source: 0 = tick_in edge, 1 = prescaler strobe.
- [4] irq enable.
- Upper bits are written-ignored and read 0.

Status register bits:
- [0] match flag (sticky).
- [1] overflow flag (sticky).
- Write-1-to-clear; upper bits read 0.

Edge detection:
- tick_last[i] registers tick_in[i] every cycle, regardless of enable.
- tick event = tick_in & ~tick_last, sampled on the same clock edge.
- The counter updates on that edge; the new value is readable the next cycle.
- A tick held high counts once.

Counting, on a tick event with enable=1:
- Stop-on-match: if cnt!=compare then cnt+1, setting match flag if cnt+1==compare; if cnt==compare, hold.
- Auto-reload: if cnt==compare then cnt<=0 and set match flag; else cnt+1. Period is compare+1 ticks. compare=0 gives a flag on every tick with cnt held at 0.
- Free-run: cnt+1 modulo 2^WIDTH, ignoring compare for hold. Set match flag if cnt+1==compare. Set overflow flag on the wrap from all-ones to 0.

Enable and writes:
- enable=0: no counting, flags unchanged.
- Write to count: cnt<=data_in, overriding any tick in the same cycle. No flag is set by the write itself, even if the written value equals compare.
- Write to compare takes effect next cycle. A tick in the same cycle compares against the old compare.
- Status clear and flag set in the same cycle: set wins.
- Channels are fully independent; a write to one channel never affects another.

Ordering and timing:
- Only one register write per cycle.
- prescale_load and wr may coincide; both take effect.
- irq and expired are combinational from registered state, so they have no added latency.

Optional Feature:
- Macro: UP_COUNTER_PRESCALE_EN.
- Defined: a shared WIDTH-bit prescaler counts sysclk cycles 0..divisor and emits a one-cycle strobe when it wraps, i.e. every divisor+1 cycles (divisor=0 gives a strobe every cycle). prescale_load sets the divisor and restarts the prescaler count at 0. A channel with ctrl[3]=1 counts strobes instead of tick_in edges.
- Not defined: the prescaler logic is absent and prescale_load is ignored. ctrl[3] is forced to 0 and reads 0, and all channels use tick_in edges only.

Test Plan:
1. Reset then read all registers → count/compare/ctrl/status 0, expired all 1, irq 0. Assert sysreset mid-count → cnt 0 immediately, without waiting for a clock.
2. Ch0: compare=5, ctrl=0x11 (enable, stop, irq); pulse tick_in[0] 7 times → cnt stops at 5, status=1, irq[0]=1 after the 5th tick. Write status=1 → irq[0]=0.
3. Ch1: compare=3, ctrl=0x03 (enable, auto-reload); 9 ticks → cnt sequence 1,2,3,0,1,2,3,0,1; match flag set. Hold tick_in high for 10 cycles → exactly one increment.
4. Ch2: count=0xFFFE, compare=0x0001, ctrl=0x05 (enable, free-run); 3 ticks → cnt 0xFFFF, 0x0000 (overflow set), 0x0001 (match set), status=3.
5. Same-cycle conflicts: count write 0x0010 with a tick edge → cnt=0x0010. Status-clear write on the tick that sets match → status bit0 remains 1. Ticks on a disabled channel → no change.
6. With UP_COUNTER_PRESCALE_EN: divisor=3, ch3 ctrl=0x09 → cnt increments every 4 sysclk cycles. Without the macro: write ctrl=0x09 → reads 0x01 and counting follows tick_in only.

Source files
------------

// File: rtl/multi_up_counter.sv
// multi_up_counter
// ----------------
// NCH independent up-counter channels that share one register write/read
// port. Each channel has a count, compare, control and status register. Each
// channel counts rising edges of its own tick input. It can run in
// stop-on-match, auto-reload or free-run mode.
//
// Build option:
//   UP_COUNTER_PRESCALE_EN - when defined, adds a shared prescaler. A channel
//   with ctrl[3]=1 counts the prescaler strobe instead of its tick_in edges.
//   When undefined, the prescaler is absent, prescale_load is ignored, and
//   ctrl[3] always reads 0.
//
// Ports:
//   sysclk        system clock
//   sysreset      asynchronous active-high reset
//   data_in       write data (also the prescaler divisor on prescale_load)
//   addr          {channel, sel}; sel 0=count 1=compare 2=control 3=status
//   wr            one-cycle write strobe for the register at addr
//   data_out      combinational read of the register at addr
//   prescale_load load data_in into the shared prescaler divisor
//   tick_in       per-channel external tick; rising edges are counted
//   expired       per-channel level, count == compare
//   irq           per-channel sticky match flag AND irq enable
//
// Control register: [0] enable, [2:1] mode (00 stop, 01 reload, 10 free,
// 11 acts as stop), [3] tick source, [4] irq enable.
// Status register: [0] match (sticky), [1] overflow (sticky); write 1 to clear.

module multi_up_counter #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CHW+1:0]   addr,
    input  logic             wr,
    output logic [WIDTH-1:0] data_out,
    input  logic             prescale_load,
    input  logic [NCH-1:0]   tick_in,
    output logic [NCH-1:0]   expired,
    output logic [NCH-1:0]   irq
);

    localparam logic [1:0] SEL_COUNT   = 2'd0;
    localparam logic [1:0] SEL_COMPARE = 2'd1;
    localparam logic [1:0] SEL_CTRL    = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_FREE   = 2'b10;

    logic [WIDTH-1:0] cnt_q  [NCH];
    logic [WIDTH-1:0] cnt_d  [NCH];
    logic [WIDTH-1:0] cmp_q  [NCH];
    logic [WIDTH-1:0] cmp_d  [NCH];
    logic [4:0]       ctrl_q [NCH];
    logic [4:0]       ctrl_d [NCH];
    logic [1:0]       stat_q [NCH];
    logic [1:0]       stat_d [NCH];
    logic [1:0]       setFlags [NCH];
    logic [1:0]       clrFlags [NCH];
    logic [WIDTH-1:0] cntInc [NCH];
    logic [NCH-1:0]   tickLast_q;
    logic [NCH-1:0]   tickEvent;
    logic [CHW-1:0]   chSel;
    logic [1:0]       regSel;
    logic             strobe;
    logic [4:0]       ctrlWriteMask;

    assign chSel  = addr[CHW+1:2];
    assign regSel = addr[1:0];

`ifdef UP_COUNTER_PRESCALE_EN
    logic [WIDTH-1:0] preDiv_q;
    logic [WIDTH-1:0] preCnt_q;

    // The prescaler counts 0..divisor and strobes on the last count. The
    // strobe is therefore one cycle wide, every divisor+1 cycles. Loading a
    // new divisor restarts the count, so the phase is known after a load.
    assign strobe        = (preCnt_q == preDiv_q);
    assign ctrlWriteMask = 5'b11111;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            preDiv_q <= '0;
            preCnt_q <= '0;
        end else if (prescale_load) begin
            preDiv_q <= data_in;
            preCnt_q <= '0;
        end else if (strobe) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_q + WIDTH'(1);
        end
    end
`else
    logic unusedPrescaleLoad;

    // Without the prescaler there is never a strobe. The tick-source bit
    // cannot be stored, so it always reads back as 0.
    assign unusedPrescaleLoad = prescale_load;
    assign strobe             = 1'b0;
    assign ctrlWriteMask      = 5'b10111;
`endif

    // Each channel picks its tick source. A level held high on tick_in
    // produces only one event, because the edge compares against last cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tickEvent[i] = ctrl_q[i][3] ? strobe : (tick_in[i] & ~tickLast_q[i]);
        end
    end

    // Next-state for every channel. The tick is applied first. A register
    // write then overrides it: a count write discards the tick and any flag
    // it would have raised. Status clear and flag set are merged so that a
    // newly raised flag survives a clear in the same cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            cmp_d[i]    = cmp_q[i];
            ctrl_d[i]   = ctrl_q[i];
            setFlags[i] = 2'b00;
            clrFlags[i] = 2'b00;
            cntInc[i]   = cnt_q[i] + WIDTH'(1);

            if (ctrl_q[i][0] && tickEvent[i]) begin
                case (ctrl_q[i][2:1])
                    MODE_RELOAD: begin
                        if (cnt_q[i] == cmp_q[i]) begin
                            cnt_d[i]       = '0;
                            setFlags[i][0] = 1'b1;
                        end else begin
                            cnt_d[i] = cntInc[i];
                        end
                    end
                    MODE_FREE: begin
                        cnt_d[i] = cntInc[i];
                        if (cntInc[i] == cmp_q[i]) begin
                            setFlags[i][0] = 1'b1;
                        end
                        if (&cnt_q[i]) begin
                            setFlags[i][1] = 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q[i] != cmp_q[i]) begin
                            cnt_d[i] = cntInc[i];
                            if (cntInc[i] == cmp_q[i]) begin
                                setFlags[i][0] = 1'b1;
                            end
                        end
                    end
                endcase
            end

            if (wr && (chSel == CHW'(i))) begin
                case (regSel)
                    SEL_COUNT: begin
                        cnt_d[i]    = data_in;
                        setFlags[i] = 2'b00;
                    end
                    SEL_COMPARE: cmp_d[i]    = data_in;
                    SEL_CTRL:    ctrl_d[i]   = data_in[4:0] & ctrlWriteMask;
                    default:     clrFlags[i] = data_in[1:0];
                endcase
            end

            stat_d[i] = (stat_q[i] & ~clrFlags[i]) | setFlags[i];
        end
    end

    // Channel state. The tick history is sampled every cycle regardless of
    // enable, so a disabled channel does not see a stale edge when re-enabled.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            tickLast_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                cmp_q[i]  <= '0;
                ctrl_q[i] <= '0;
                stat_q[i] <= '0;
            end
        end else begin
            tickLast_q <= tick_in;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                cmp_q[i]  <= cmp_d[i];
                ctrl_q[i] <= ctrl_d[i];
                stat_q[i] <= stat_d[i];
            end
        end
    end

    // Read mux. A channel number beyond NCH-1 reads as zero.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chSel == CHW'(i)) begin
                case (regSel)
                    SEL_COUNT:   data_out = cnt_q[i];
                    SEL_COMPARE: data_out = cmp_q[i];
                    SEL_CTRL:    data_out = {{(WIDTH-5){1'b0}}, ctrl_q[i]};
                    default:     data_out = {{(WIDTH-2){1'b0}}, stat_q[i]};
                endcase
            end
        end
    end

    // Level outputs straight from registered state.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            expired[i] = (cnt_q[i] == cmp_q[i]);
            irq[i]     = stat_q[i][0] & ctrl_q[i][4];
        end
    end

endmodule

// File: tb/tb_multi_up_counter.sv
// Testbench for multi_up_counter. A behavioural model of all channels is
// stepped on every clock edge. The outputs are compared with it on every
// falling edge. Directed sequences pin the model against hand-computed values.
// Randomized traffic then exercises all channels and modes.
// Prescaler checks follow UP_COUNTER_PRESCALE_EN.

module tb_multi_up_counter;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int CHW   = 2;

    logic             sysclk        = 1'b0;
    logic             sysreset      = 1'b1;
    logic [WIDTH-1:0] data_in       = '0;
    logic [CHW+1:0]   addr          = '0;
    logic             wr            = 1'b0;
    logic             prescale_load = 1'b0;
    logic [NCH-1:0]   tick_in       = '0;
    logic [WIDTH-1:0] data_out;
    logic [NCH-1:0]   expired;
    logic [NCH-1:0]   irq;

    int checks = 0;
    int fails  = 0;

    multi_up_counter #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .data_in       (data_in),
        .addr          (addr),
        .wr            (wr),
        .data_out      (data_out),
        .prescale_load (prescale_load),
        .tick_in       (tick_in),
        .expired       (expired),
        .irq           (irq)
    );

    always #5 sysclk = ~sysclk;

    // Reference model state
    logic [WIDTH-1:0] mCnt  [NCH];
    logic [WIDTH-1:0] mCmp  [NCH];
    logic [4:0]       mCtrl [NCH];
    logic [1:0]       mStat [NCH];
    logic [NCH-1:0]   mLast;
    logic [WIDTH-1:0] mDiv;
    logic [WIDTH-1:0] mPc;

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            mCnt[i]  = '0;
            mCmp[i]  = '0;
            mCtrl[i] = '0;
            mStat[i] = '0;
        end
        mLast = '0;
        mDiv  = '0;
        mPc   = '0;
    endtask

    // One clock of channel behaviour, written from the counting rules.
    task automatic modelStep();
        bit          strobe;
        bit          ev;
        bit [1:0]    setF;
        bit [1:0]    clrF;
        longint      nxt;
        int          ch;
        int          sel;
        ch     = int'(addr[CHW+1:2]);
        sel    = int'(addr[1:0]);
        strobe = (mPc == mDiv);
        for (int i = 0; i < NCH; i++) begin
            ev = tick_in[i] && !mLast[i];
`ifdef UP_COUNTER_PRESCALE_EN
            if (mCtrl[i][3]) ev = strobe;
`endif
            setF = 2'b00;
            clrF = 2'b00;
            if (mCtrl[i][0] && ev) begin
                nxt = (longint'(mCnt[i]) + 1) % (longint'(1) << WIDTH);
                if (mCtrl[i][2:1] == 2'b01) begin
                    if (mCnt[i] == mCmp[i]) begin
                        mCnt[i] = '0;
                        setF[0] = 1'b1;
                    end else begin
                        mCnt[i] = WIDTH'(nxt);
                    end
                end else if (mCtrl[i][2:1] == 2'b10) begin
                    if (nxt == longint'(mCmp[i])) setF[0] = 1'b1;
                    if (nxt == 0) setF[1] = 1'b1;
                    mCnt[i] = WIDTH'(nxt);
                end else begin
                    if (mCnt[i] != mCmp[i]) begin
                        if (nxt == longint'(mCmp[i])) setF[0] = 1'b1;
                        mCnt[i] = WIDTH'(nxt);
                    end
                end
            end
            if (wr && ch == i) begin
                case (sel)
                    0: begin mCnt[i] = data_in; setF = 2'b00; end
                    1: mCmp[i] = data_in;
`ifdef UP_COUNTER_PRESCALE_EN
                    2: mCtrl[i] = data_in[4:0];
`else
                    2: mCtrl[i] = data_in[4:0] & 5'b10111;
`endif
                    default: clrF = data_in[1:0];
                endcase
            end
            mStat[i] = (mStat[i] & ~clrF) | setF;
            mLast[i] = tick_in[i];
        end
`ifdef UP_COUNTER_PRESCALE_EN
        if (prescale_load) begin
            mDiv = data_in;
            mPc  = '0;
        end else if (strobe) begin
            mPc = '0;
        end else begin
            mPc = mPc + WIDTH'(1);
        end
`endif
    endtask

    function automatic logic [31:0] modelRead(logic [CHW+1:0] a);
        int ch;
        ch = int'(a[CHW+1:2]);
        case (a[1:0])
            2'd0:    return 32'(mCnt[ch]);
            2'd1:    return 32'(mCmp[ch]);
            2'd2:    return 32'(mCtrl[ch]);
            default: return 32'(mStat[ch]);
        endcase
    endfunction

    function automatic logic [31:0] modelExpired();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (mCnt[i] == mCmp[i]);
        return v;
    endfunction

    function automatic logic [31:0] modelIrq();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = mStat[i][0] && mCtrl[i][4];
        return v;
    endfunction

    always @(posedge sysclk or posedge sysreset) begin
        if (sysreset) modelReset();
        else          modelStep();
    end

    // Continuous comparison, away from the active edge.
    always @(negedge sysclk) begin
        checkOutput("data_out", 32'(data_out), modelRead(addr));
        checkOutput("expired", 32'(expired), modelExpired());
        checkOutput("irq", 32'(irq), modelIrq());
    end

    task automatic nextCycle();
        @(posedge sysclk);
        #1;
    endtask

    task automatic applyStimulus(int ch, int sel, logic [WIDTH-1:0] val);
        addr    = (CHW+2)'(ch * 4 + sel);
        data_in = val;
        wr      = 1'b1;
        nextCycle();
        wr      = 1'b0;
    endtask

    task automatic pulseTick(int ch);
        tick_in[ch] = 1'b1;
        nextCycle();
        tick_in[ch] = 1'b0;
        nextCycle();
    endtask

    task automatic readCheck(string name, int ch, int sel, logic [31:0] expected);
        addr = (CHW+2)'(ch * 4 + sel);
        #1;
        checkOutput(name, 32'(data_out), expected);
    endtask

    int reloadSeq [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

    initial begin
        // Reset values
        sysreset = 1'b1;
        repeat (3) nextCycle();
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < 4; s++) begin
                readCheck($sformatf("reset_ch%0d_sel%0d", c, s), c, s, 32'h0);
            end
        end
        checkOutput("reset_expired", 32'(expired), 32'hF);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        sysreset = 1'b0;
        nextCycle();

        // Stop-on-match on channel 0
        applyStimulus(0, 1, 16'd5);
        applyStimulus(0, 2, 16'h11);
        for (int k = 0; k < 7; k++) pulseTick(0);
        readCheck("stop_cnt", 0, 0, 32'd5);
        readCheck("stop_status", 0, 3, 32'd1);
        checkOutput("stop_irq0", 32'(irq[0]), 32'd1);
        applyStimulus(0, 3, 16'd1);
        #1;
        checkOutput("stop_irq0_cleared", 32'(irq[0]), 32'd0);

        // Auto-reload on channel 1
        applyStimulus(1, 1, 16'd3);
        applyStimulus(1, 2, 16'h03);
        for (int k = 0; k < 9; k++) begin
            pulseTick(1);
            readCheck($sformatf("reload_cnt_%0d", k), 1, 0, 32'(reloadSeq[k]));
        end
        readCheck("reload_status", 1, 3, 32'd1);
        tick_in[1] = 1'b1;
        repeat (10) nextCycle();
        tick_in[1] = 1'b0;
        nextCycle();
        readCheck("held_tick_cnt", 1, 0, 32'd2);

        // Free-run wrap on channel 2
        applyStimulus(2, 0, 16'hFFFE);
        applyStimulus(2, 1, 16'h0001);
        applyStimulus(2, 2, 16'h05);
        pulseTick(2);
        readCheck("free_cnt_ffff", 2, 0, 32'hFFFF);
        pulseTick(2);
        readCheck("free_cnt_wrap", 2, 0, 32'h0);
        readCheck("free_status_ovf", 2, 3, 32'd2);
        pulseTick(2);
        readCheck("free_cnt_one", 2, 0, 32'h1);
        readCheck("free_status_both", 2, 3, 32'd3);

        // Same-cycle conflicts on channel 3
        applyStimulus(3, 1, 16'h20);
        applyStimulus(3, 2, 16'h01);
        addr = 4'(3 * 4 + 0); data_in = 16'h10; wr = 1'b1; tick_in[3] = 1'b1;
        nextCycle();
        wr = 1'b0; tick_in[3] = 1'b0;
        nextCycle();
        readCheck("write_beats_tick", 3, 0, 32'h10);
        applyStimulus(3, 0, 16'h0);
        applyStimulus(3, 1, 16'h2);
        pulseTick(3);
        addr = 4'(3 * 4 + 3); data_in = 16'h1; wr = 1'b1; tick_in[3] = 1'b1;
        nextCycle();
        wr = 1'b0; tick_in[3] = 1'b0;
        nextCycle();
        readCheck("set_beats_clear_status", 3, 3, 32'd1);
        readCheck("set_beats_clear_cnt", 3, 0, 32'd2);
        applyStimulus(3, 0, 16'h0);
        applyStimulus(3, 2, 16'h0);
        for (int k = 0; k < 3; k++) pulseTick(3);
        readCheck("disabled_cnt", 3, 0, 32'd0);
        readCheck("disabled_status", 3, 3, 32'd1);

        // Tick source selection
`ifdef UP_COUNTER_PRESCALE_EN
        begin
            logic [WIDTH-1:0] base;
            data_in = 16'd3; prescale_load = 1'b1;
            nextCycle();
            prescale_load = 1'b0;
            applyStimulus(3, 1, 16'h100);
            applyStimulus(3, 2, 16'h09);
            base = mCnt[3];
            repeat (40) nextCycle();
            readCheck("prescale_cnt", 3, 0, 32'(base + 16'd10));
        end
`else
        applyStimulus(3, 2, 16'h09);
        readCheck("ctrl_bit3_masked", 3, 2, 32'h01);
        applyStimulus(3, 1, 16'h100);
        for (int k = 0; k < 3; k++) pulseTick(3);
        repeat (20) nextCycle();
        readCheck("tick_only_cnt", 3, 0, 32'd3);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick_in       = NCH'($urandom);
            addr          = (CHW+2)'($urandom);
            wr            = ($urandom_range(0, 3) == 0);
            prescale_load = ($urandom_range(0, 63) == 0);
            if (prescale_load)
                data_in = WIDTH'($urandom_range(0, 4));
            else if (addr[1:0] == 2'd2)
                data_in = WIDTH'($urandom);
            else if ($urandom_range(0, 3) == 0)
                data_in = WIDTH'(16'hFFF8 + $urandom_range(0, 7));
            else
                data_in = WIDTH'($urandom_range(0, 7));
            nextCycle();
        end
        wr = 1'b0; prescale_load = 1'b0; tick_in = '0;
        nextCycle();

        // Asynchronous reset mid-count
        applyStimulus(0, 0, 16'h1234);
        readCheck("pre_reset_cnt", 0, 0, 32'h1234);
        sysreset = 1'b1;
        #1;
        checkOutput("async_reset_cnt", 32'(data_out), 32'h0);
        checkOutput("async_reset_expired", 32'(expired), 32'hF);
        nextCycle();
        sysreset = 1'b0;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
